// File: rtl/led_afterglow.sv
// led_afterglow: output stage between the datapath LED pattern and the board pins.
// Lit LEDs drive at full brightness; a dropped bit fades out over 15 PWM levels.
module led_afterglow #(
    parameter int unsigned N_LED     = 27,
    parameter int unsigned LEVEL_W   = 4,
    parameter int unsigned PWM_DIV   = 4096,
    parameter int unsigned DECAY_DIV = 8
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             en,
    input  logic             fade_en,
    input  logic [N_LED-1:0] pattern_in,
    output logic [N_LED-1:0] led_out,
    output logic             frame_tick
);

    localparam int unsigned PRE_W        = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned DEC_W        = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam int unsigned PHASE_LAST_I = (1 << LEVEL_W) - 2;

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(PWM_DIV - 1);
    localparam logic [DEC_W-1:0]   DEC_LAST   = DEC_W'(DECAY_DIV - 1);
    localparam logic [LEVEL_W-1:0] PHASE_LAST = LEVEL_W'(PHASE_LAST_I);
    localparam logic [LEVEL_W-1:0] LVL_MAX    = '1;

    logic [PRE_W-1:0]   pre_q,   pre_d;
    logic [LEVEL_W-1:0] phase_q, phase_d;
    logic [DEC_W-1:0]   dec_q,   dec_d;
    logic [N_LED-1:0]   s1_q,    s2_q;
    logic [LEVEL_W-1:0] level_q [N_LED];
    logic [LEVEL_W-1:0] level_d [N_LED];
    logic [N_LED-1:0]   led_q,   led_d;
    logic               ft_q,    ft_d;

    logic slot_tick_c;
    logic frame_end_c;
    logic decay_tick_c;

    // Shared timing strobes derived from the current counter state
    always_comb begin
        slot_tick_c  = (pre_q == PRE_LAST);
        frame_end_c  = slot_tick_c && (phase_q == PHASE_LAST);
        decay_tick_c = frame_end_c && (dec_q == DEC_LAST);
    end

    // Next state of prescaler, phase, decay counter and frame pulse; all freeze when en=0
    always_comb begin
        pre_d   = pre_q;
        phase_d = phase_q;
        dec_d   = dec_q;
        ft_d    = 1'b0;
        if (en) begin
            pre_d = slot_tick_c ? '0 : pre_q + PRE_W'(1);
            if (slot_tick_c) begin
                phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + LEVEL_W'(1);
            end
            if (frame_end_c) begin
                dec_d = (dec_q == DEC_LAST) ? '0 : dec_q + DEC_W'(1);
            end
            ft_d = frame_end_c;
        end
    end

    // Per-LED brightness level and PWM compare; a set bit always reloads full level
    always_comb begin
        led_d = led_q;
        for (int i = 0; i < int'(N_LED); i++) begin
            level_d[i] = level_q[i];
            if (en) begin
                if (s2_q[i]) begin
                    level_d[i] = LVL_MAX;
                end else if (!fade_en) begin
                    level_d[i] = '0;
                end else if (decay_tick_c && (level_q[i] != '0)) begin
                    level_d[i] = level_q[i] - LEVEL_W'(1);
                end
                led_d[i] = (level_q[i] > phase_q);
            end
        end
    end

    // State registers; the pattern synchroniser keeps sampling regardless of en
    always_ff @(posedge clk_50) begin
        if (!rst) begin
            pre_q   <= '0;
            phase_q <= '0;
            dec_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            led_q   <= '0;
            ft_q    <= 1'b0;
            for (int i = 0; i < int'(N_LED); i++) begin
                level_q[i] <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
            dec_q   <= dec_d;
            s1_q    <= pattern_in;
            s2_q    <= s1_q;
            led_q   <= led_d;
            ft_q    <= ft_d;
            for (int i = 0; i < int'(N_LED); i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign led_out    = led_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_led_afterglow.sv
// tb_led_afterglow: directed scoreboard bench for led_afterglow (PWM_DIV=2, DECAY_DIV=2).
module tb_led_afterglow;

    localparam logic [26:0] ALL1 = 27'h7FFFFFF;
    localparam logic [26:0] EVEN = 27'h5555555;
    localparam logic [26:0] ODD  = 27'h2AAAAAA;

    logic        clk_50 = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        fade_en = 1'b0;
    logic [26:0] pattern_in = '0;
    logic [26:0] led_out;
    logic        frame_tick;

    int n_cmp = 0;
    int n_mis = 0;
    int ft_count = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk_50 = ~clk_50;

    led_afterglow #(
        .N_LED    (27),
        .LEVEL_W  (4),
        .PWM_DIV  (2),
        .DECAY_DIV(2)
    ) dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .en        (en),
        .fade_en   (fade_en),
        .pattern_in(pattern_in),
        .led_out   (led_out),
        .frame_tick(frame_tick)
    );

    // Record an expectation at the moment the stimulus is applied
    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with what the DUT produced
    task automatic sb_pop_check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed 0x%0h with nothing expected", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_mis++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge; tracks frame pulses since reset
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50);
            #1;
            if (!rst) ft_count = 0;
            else if (frame_tick) ft_count++;
        end
    endtask

    // Wait for the next frame_tick, bounded by budget cycles
    task automatic wait_pulse(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            tick(1);
            cycles++;
            if (frame_tick) break;
        end
        if (!frame_tick) begin
            sb_push("pulse_timeout", 32'd1);
            sb_pop_check(32'(frame_tick));
        end
    endtask

    // Stop right after a frame pulse that coincided with a decay step (even pulse count)
    task automatic align_even();
        int c;
        int k;
        k = 0;
        do begin
            wait_pulse(40, c);
            k++;
        end while (((ft_count % 2) != 0) && (k < 4));
        sb_push("align_parity", 32'd0);
        sb_pop_check(32'(ft_count % 2));
    endtask

    // One 30-cycle PWM frame: count bit0 on-cycles and flag shape violations
    task automatic window(input logic [26:0] grp, input logic [26:0] zero_m,
                          input logic [26:0] one_m, output int ones, output int bad);
        logic [26:0] g;
        ones = 0;
        bad  = 0;
        for (int s = 0; s < 30; s++) begin
            tick(1);
            if (led_out[0]) ones++;
            if ((led_out & zero_m) != '0) bad++;
            if ((led_out & one_m) != one_m) bad++;
            g = led_out & grp;
            if ((g != '0) && (g != grp)) bad++;
        end
        if (!frame_tick) bad++;
    endtask

    // Check duty of frames first..last after a fall aligned to a decay step
    task automatic fade_windows(input int first, input int last, input logic [26:0] grp,
                                input logic [26:0] zero_m, input logic [26:0] one_m,
                                input string tag);
        int lvl;
        int ones;
        int bad;
        for (int w = first; w <= last; w++) begin
            lvl = 15 - ((w - 1) / 2);
            if (lvl < 0) lvl = 0;
            sb_push($sformatf("%s_duty_w%0d", tag, w), 32'(2 * lvl));
            sb_push($sformatf("%s_shape_w%0d", tag, w), 32'd0);
            window(grp, zero_m, one_m, ones, bad);
            sb_pop_check(32'(ones));
            sb_pop_check(32'(bad));
        end
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        int c;
        int seen;
        int ones;

        // Reset holds everything low even with an all-ones pattern
        rst        = 1'b0;
        en         = 1'b1;
        fade_en    = 1'b1;
        pattern_in = ALL1;
        for (int i = 0; i < 3; i++) begin
            sb_push("rst_led", 32'd0);
            sb_push("rst_ft", 32'd0);
            tick(1);
            sb_pop_check(32'(led_out));
            sb_pop_check(32'(frame_tick));
        end
        rst = 1'b1;
        sb_push("release_e3", 32'd0);
        tick(3);
        sb_pop_check(32'(led_out));
        sb_push("release_e4", 32'(ALL1));
        tick(1);
        sb_pop_check(32'(led_out));

        // Frame timing: 30-cycle period, single-cycle pulse
        sb_push("first_frame", 32'd26);
        wait_pulse(40, c);
        sb_pop_check(32'(c));
        sb_push("ft_width", 32'd0);
        tick(1);
        sb_pop_check(32'(frame_tick));
        sb_push("period_a", 32'd29);
        wait_pulse(40, c);
        sb_pop_check(32'(c));
        sb_push("period_b", 32'd30);
        wait_pulse(40, c);
        sb_pop_check(32'(c));

        // en=0 for 10 cycles mid-frame delays the next pulse by 10
        tick(5);
        en   = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (frame_tick) seen++;
        end
        en = 1'b1;
        sb_push("pause_ft", 32'd0);
        sb_pop_check(32'(seen));
        sb_push("delayed_period", 32'd25);
        wait_pulse(60, c);
        sb_pop_check(32'(c));

        // Only bit 0 lit; other channels cleared without fade
        fade_en    = 1'b0;
        pattern_in = 27'h0000001;
        sb_push("single_bit", 32'h1);
        tick(4);
        sb_pop_check(32'(led_out));

        // Full fade of bit 0: duty 15,15,14,14,...,1,1 then off
        fade_en = 1'b1;
        align_even();
        pattern_in = '0;
        fade_windows(1, 32, 27'h1, ~27'h1, 27'h0, "fade");

        // No fade: bit 26 follows the pattern with 4-edge latency both ways
        fade_en    = 1'b0;
        pattern_in = 27'h4000000;
        sb_push("nf_rise_e3", 32'd0);
        tick(3);
        sb_pop_check(32'(led_out));
        sb_push("nf_rise_e4", 32'h4000000);
        tick(1);
        sb_pop_check(32'(led_out));
        pattern_in = '0;
        sb_push("nf_fall_e3", 32'h4000000);
        tick(3);
        sb_pop_check(32'(led_out));
        sb_push("nf_fall_e4", 32'd0);
        tick(1);
        sb_pop_check(32'(led_out));

        // Re-trigger at level 7, then fade restarts from full
        fade_en    = 1'b1;
        pattern_in = 27'h0000001;
        tick(4);
        align_even();
        pattern_in = '0;
        fade_windows(1, 17, 27'h1, ~27'h1, 27'h0, "retrig");
        tick(5);
        pattern_in = 27'h0000001;
        tick(3);
        sb_push("retrig_on", 32'd1);
        tick(1);
        sb_pop_check(32'(led_out[0]));
        ones = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (led_out[0]) ones++;
        end
        sb_push("retrig_solid", 32'd30);
        sb_pop_check(32'(ones));
        align_even();
        pattern_in = '0;
        fade_windows(1, 4, 27'h1, ~27'h1, 27'h0, "refade");

        // Mixed channels: odd bits go solid while even bits fade together
        pattern_in = EVEN;
        sb_push("mix_even", 32'(EVEN));
        tick(4);
        sb_pop_check(32'(led_out));
        align_even();
        pattern_in = ODD;
        sb_push("mix_odd_e3", 32'd0);
        tick(3);
        sb_pop_check(32'(led_out & ODD));
        sb_push("mix_odd_e4", 32'(ALL1));
        tick(1);
        sb_pop_check(32'(led_out));
        sb_push("mix_w1_end", 32'd1);
        tick(26);
        sb_pop_check(32'(frame_tick));
        fade_windows(2, 5, EVEN, 27'h0, ODD, "mix");

        // Reset mid-fade clears every output on the next edge with no residual glow
        tick(7);
        rst = 1'b0;
        sb_push("midrst_led", 32'd0);
        sb_push("midrst_ft", 32'd0);
        tick(1);
        sb_pop_check(32'(led_out));
        sb_pop_check(32'(frame_tick));
        pattern_in = '0;
        tick(2);
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 35; i++) begin
            tick(1);
            if (led_out != '0) seen++;
        end
        sb_push("no_glow", 32'd0);
        sb_pop_check(32'(seen));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/led_afterglow.md
Name: led_afterglow

Overview:
- Downstream output stage between the datapath's 27-bit LED pattern and the board LED pins.
- Adds a per-LED PWM "afterglow":
  - A lit LED shows at full brightness.
  - When its pattern bit drops, it fades out in 15 brightness steps instead of switching off at once.
- Runs on clk_50 and synchronises the pattern, which is produced in the divided-clock domain.

Parameters:
- N_LED, 27: number of LED channels.
- LEVEL_W, 4: brightness level width. Levels 0..15, 15 PWM slots per frame.
- PWM_DIV, 4096: clk_50 cycles per PWM slot. Minimum 2.
- DECAY_DIV, 8: PWM frames per one-level decay step. Minimum 1.

Ports:
- clk_50  input  1  system clock, 50 MHz.
- rst  input  1  synchronous reset, active-low; sampled on the clk_50 rising edge.
- en  input  1  1 = run; 0 = freeze all counters, levels and outputs.
- fade_en  input  1  1 = afterglow fade; 0 = LED off as soon as its pattern bit is 0.
- pattern_in  input  N_LED  LED pattern from the datapath, asynchronous to clk_50.
- led_out  output  N_LED  PWM-modulated LED drive, registered.
- frame_tick  output  1  one-cycle pulse at the end of each PWM frame.

Behaviour:
- Reset (rst=0 at an edge):
  - Prescaler, phase, decay counter, sync flops and all levels go to 0.
  - led_out = 0 and frame_tick = 0.
  - Reset has priority over en.
- Synchroniser: pattern_in passes through 2 flops (s1, s2). Only s2 is used downstream.
- Prescaler:
  - Counts 0..PWM_DIV-1 and wraps.
  - slot_tick = 1 when the prescaler is at PWM_DIV-1.
- Phase counter:
  - Counts 0..14. It advances on slot_tick and wraps 14 -> 0.
  - frame_end = slot_tick AND phase == 14.
- frame_tick: registered copy of frame_end, high for exactly 1 cycle per frame.
- Decay counter:
  - Counts 0..DECAY_DIV-1 and advances on frame_end.
  - decay_tick = frame_end AND decay count == DECAY_DIV-1.
- Per-LED level update each enabled cycle, priority order:
  1. s2[i]=1 -> level=15. This reloads even while fading.
  2. s2[i]=0 and fade_en=0 -> level=0.
  3. s2[i]=0, fade_en=1, decay_tick=1 and level>0 -> level-1.
  4. Otherwise level holds. It saturates at 0 and never wraps.
- Output: led_out[i] registered as (level[i] > phase).
  - Level 15 gives always on.
  - Level 0 gives always off.
  - Level L gives L of 15 slots on per frame.
- Latency: a pattern_in change becomes visible on led_out at the 4th rising clk_50 edge after the change.
  - Edge 1: s1. Edge 2: s2. Edge 3: level. Edge 4: led_out.
  - This holds for a rise, and for a fall with fade_en=0.
- en=0:
  - Prescaler, phase, decay counter, levels, led_out and frame_tick registers hold.
  - frame_tick is forced 0.
  - Sync flops keep sampling.
- en re-asserted: counting resumes from the held values with no skipped or extra tick.
- fade_en dropped mid-fade: every LED with s2=0 goes to level 0 on the next cycle. The output goes low one cycle after that.
- Bit re-asserted mid-fade: its level returns to 15 with no intermediate step.
- Reset mid-fade: all levels clear immediately; there is no residual glow.
- All channels are independent. The counters are shared, so all fading LEDs step on the same decay_tick.

Test Plan (sim parameters PWM_DIV=2, DECAY_DIV=2, so frame = 30 cycles and decay step = 60 cycles):
- Reset: hold rst=0 for 3 cycles with pattern_in=all 1s -> led_out=0 and frame_tick=0 throughout. Release with en=1 -> led_out = all 1s at the 4th edge after the release edge.
- Frame timing: en=1 free-running -> frame_tick pulses every 30 cycles, each exactly 1 cycle wide. With en=0 for 10 cycles mid-frame, the next pulse is delayed by exactly 10 cycles.
- Fade: fade_en=1, pattern_in=0x0000001 then 0x0000000 -> led_out[0] stays solid until the first decay_tick.
  - Duty per frame then steps 14/15, 13/15, ..., 1/15, with each duty level lasting 2 frames.
  - After the 15th decay_tick led_out[0]=0 permanently, at most 900 + 60 cycles after the fall.
  - Other bits stay 0 throughout.
- No fade: fade_en=0, pattern_in 0x4000000 -> 0 -> led_out[26] falls exactly at the 4th edge after the change.
- Re-trigger: during a fade at level 7, set pattern_in[0]=1 -> level is 15 (solid on) at the 4th edge. Clear again -> fade restarts from 15.
- Mixed channels: pattern_in=0x5555555 held, then 0x2AAAAAA -> odd bits go solid 4 edges after the change while even bits fade in lockstep. Assert reset mid-fade -> all led_out=0 on the next edge.
